// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and sizing for the iterative FP sequencer
package fpu_pkg;

    localparam int EXP_W_DEF     = 8;
    localparam int MAN_W_DEF     = 23;
    localparam int ALIGN_MAX_DEF = MAN_W_DEF + 3;

    typedef enum logic [1:0] {
        FP_ADD  = 2'b00,
        FP_SUB  = 2'b01,
        FP_MUL  = 2'b10,
        FP_RSVD = 2'b11
    } fp_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ALIGN,
        ST_ADD,
        ST_MUL,
        ST_NORM,
        ST_ROUND,
        ST_PACK
    } seq_state_e;

    function automatic int align_max(input int man_w);
        return man_w + 3;
    endfunction

endpackage

// File: rtl/fpu_step_counter.sv
// rtl/fpu_step_counter.sv - loadable down-counter bounding align, multiply and normalize loops
module fpu_step_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign last_o = (cnt_q == W'(1));
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// rtl/fpu_seq_ctrl.sv - step sequencer for shared FP add/sub/mul datapath; FPU_SEQ_MUL_EN enables multiply
module fpu_seq_ctrl
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       FpOp,
    input  logic [EXP_W:0]   ExpDiff,
    input  logic             SpecialIn,
    input  logic             ResMsb,
    input  logic             ResHidden,
    input  logic             ResZero,
    output logic             LoadOps,
    output logic             SwapOps,
    output logic             AlignShift,
    output logic             AddSub,
    output logic             MulStep,
    output logic             NormLeft,
    output logic             NormRight,
    output logic             RoundEn,
    output logic             PackW,
    output logic             SpecialSel,
    output logic             Invalid,
    output logic             Busy,
    output logic             Done
);

    localparam int ALIGN_MAX = align_max(MAN_W);
    localparam int CNT_W     = $clog2(MAN_W + 4);
    localparam logic [CNT_W-1:0]   STEP_CNT  = CNT_W'(MAN_W + 1);
    localparam logic [CNT_W-1:0]   ALIGN_CNT = CNT_W'(ALIGN_MAX);
    localparam logic [EXP_W+1:0]   ALIGN_LIM = (EXP_W + 2)'(ALIGN_MAX);
`ifdef FPU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    seq_state_e state_q;
    logic       special_q;
    logic       invalid_q;

    logic [EXP_W+1:0] exp_ext;
    logic [EXP_W+1:0] exp_abs;
    logic [CNT_W-1:0] align_cnt;
    logic             is_rsvd;
    logic             is_special;
    logic             is_mul;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_last;
    logic             cnt_zero;

    // One extra bit of width so negating the most negative difference cannot overflow.
    assign exp_ext   = {ExpDiff[EXP_W], ExpDiff};
    assign exp_abs   = ExpDiff[EXP_W] ? (~exp_ext + (EXP_W + 2)'(1)) : exp_ext;
    assign align_cnt = (exp_abs > ALIGN_LIM) ? ALIGN_CNT : exp_abs[CNT_W-1:0];

    assign is_rsvd    = (FpOp == FP_RSVD) || (!MUL_EN && (FpOp == FP_MUL));
    assign is_special = SpecialIn || is_rsvd;
    assign is_mul     = MUL_EN && (FpOp == FP_MUL);

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = STEP_CNT;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = is_mul ? STEP_CNT : align_cnt;
            end
            ST_ALIGN: cnt_dec = 1'b1;
            ST_ADD:   cnt_load = 1'b1;
            ST_MUL: begin
                cnt_load = cnt_zero;
                cnt_dec  = !cnt_zero;
            end
            ST_NORM:  cnt_dec = NormLeft;
            default: ;
        endcase
    end

    fpu_step_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            special_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (Start) begin
                    state_q   <= ST_LOAD;
                    invalid_q <= 1'b0;
                end
                ST_LOAD: begin
                    special_q <= is_special;
                    if (is_special) begin
                        state_q   <= ST_PACK;
                        invalid_q <= is_rsvd;
                    end else if (is_mul) begin
                        state_q <= ST_MUL;
                    end else if (align_cnt != '0) begin
                        state_q <= ST_ALIGN;
                    end else begin
                        state_q <= ST_ADD;
                    end
                end
                ST_ALIGN: if (cnt_last) state_q <= ST_ADD;
                ST_ADD:   state_q <= ST_NORM;
                // Counter drained: one accumulate cycle without MulStep, then normalize.
                ST_MUL:   if (cnt_zero) state_q <= ST_NORM;
                ST_NORM: begin
                    if (ResZero) begin
                        state_q <= ST_PACK;
                    end else if (ResMsb || ResHidden || cnt_zero) begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: state_q <= ST_PACK;
                ST_PACK:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign LoadOps    = (state_q == ST_LOAD);
    assign SwapOps    = (state_q == ST_LOAD) && ExpDiff[EXP_W];
    assign AlignShift = (state_q == ST_ALIGN);
    assign AddSub     = (state_q == ST_ADD);
`ifdef FPU_SEQ_MUL_EN
    assign MulStep    = (state_q == ST_MUL) && !cnt_zero;
`else
    assign MulStep    = 1'b0;
`endif
    assign NormRight  = (state_q == ST_NORM) && !ResZero && ResMsb;
    assign NormLeft   = (state_q == ST_NORM) && !ResZero && !ResMsb && !ResHidden && !cnt_zero;
    assign RoundEn    = (state_q == ST_ROUND);
    assign PackW      = (state_q == ST_PACK);
    assign Done       = (state_q == ST_PACK);
    assign SpecialSel = (state_q == ST_PACK) && special_q;
    assign Invalid    = invalid_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb/tb_fpu_seq_ctrl.sv - self-checking bench for fpu_seq_ctrl against a latency/strobe-count model
module tb_fpu_seq_ctrl;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int ALIGN_MAX = MAN_W + 3;
    localparam int STEPS     = MAN_W + 1;
    localparam int K_MSB = 0, K_HID = 1, K_ZERO = 2, K_NEVER = 3;
`ifdef FPU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic Start = 1'b0;
    logic [1:0] FpOp = 2'b00;
    logic [EXP_W:0] ExpDiff = '0;
    logic SpecialIn = 1'b0, ResMsb = 1'b0, ResHidden = 1'b0, ResZero = 1'b0;
    logic LoadOps, SwapOps, AlignShift, AddSub, MulStep, NormLeft, NormRight;
    logic RoundEn, PackW, SpecialSel, Invalid, Busy, Done;
    logic [12:0] outs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign outs = {LoadOps, SwapOps, AlignShift, AddSub, MulStep, NormLeft, NormRight,
                   RoundEn, PackW, SpecialSel, Invalid, Busy, Done};

    fpu_seq_ctrl #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .FpOp(FpOp), .ExpDiff(ExpDiff),
        .SpecialIn(SpecialIn), .ResMsb(ResMsb), .ResHidden(ResHidden), .ResZero(ResZero),
        .LoadOps(LoadOps), .SwapOps(SwapOps), .AlignShift(AlignShift), .AddSub(AddSub),
        .MulStep(MulStep), .NormLeft(NormLeft), .NormRight(NormRight), .RoundEn(RoundEn),
        .PackW(PackW), .SpecialSel(SpecialSel), .Invalid(Invalid), .Busy(Busy), .Done(Done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one operation and plays the datapath role in NORM: the result becomes
    // normalized (or zero) after k left shifts, or reports mantissa overflow at once.
    task automatic run_op(input logic [1:0] op, input int e, input bit spec,
                          input int kind, input int k, input bit hold);
        logic [EXP_W:0] ed;
        int a, n, lat, ae;
        bit rsvd, special, is_mul, zero_res;
        int c_align, c_mul, c_left, c_right, c_round, c_add, c_load, done_cyc;
        int shifts, busy_bad, packw_bad;
        logic swap0, inv0, spec_d, inv_d;

        ed       = e[EXP_W:0];
        ae       = (e < 0) ? -e : e;
        a        = (ae > ALIGN_MAX) ? ALIGN_MAX : ae;
        rsvd     = (op == 2'b11) || (op == 2'b10 && !MUL_EN);
        special  = spec || rsvd;
        is_mul   = (op == 2'b10) && !special;
        zero_res = (kind == K_ZERO) && !special;
        n        = special ? 0 : (kind == K_MSB) ? 0 : (kind == K_NEVER) ? STEPS : k;
        lat      = special ? 1 : ((is_mul ? 4 + STEPS : 4 + a) + n - int'(zero_res));

        c_align = 0; c_mul = 0; c_left = 0; c_right = 0; c_round = 0; c_add = 0; c_load = 0;
        done_cyc = -1; shifts = 0; busy_bad = 0; packw_bad = 0;
        swap0 = 1'b0; inv0 = 1'b0; spec_d = 1'b0; inv_d = 1'b0;

        @(negedge clk);
        FpOp = op; ExpDiff = ed; SpecialIn = spec;
        ResMsb = 1'b0; ResHidden = 1'b0; ResZero = 1'b0;
        Start = 1'b1;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            @(posedge clk);
            #1;
            if (!hold) Start = 1'b0;
            ResMsb    = (kind == K_MSB);
            ResHidden = (kind == K_HID) && (shifts >= k);
            ResZero   = (kind == K_ZERO) && (shifts >= k);
            @(negedge clk);
            if (cyc == 0) begin
                swap0 = SwapOps;
                inv0  = Invalid;
            end
            c_align += int'(AlignShift);
            c_mul   += int'(MulStep);
            c_left  += int'(NormLeft);
            c_right += int'(NormRight);
            c_round += int'(RoundEn);
            c_add   += int'(AddSub);
            c_load  += int'(LoadOps);
            if (NormLeft) shifts++;
            if (Busy !== 1'b1) busy_bad++;
            if (PackW !== Done) packw_bad++;
            if (Done === 1'b1) begin
                done_cyc = cyc;
                spec_d   = SpecialSel;
                inv_d    = Invalid;
                Start    = 1'b0;
            end
        end
        ResMsb = 1'b0; ResHidden = 1'b0; ResZero = 1'b0;

        check("done_cycle", done_cyc, lat);
        check("align_shifts", c_align, (special || is_mul) ? 0 : a);
        check("mul_steps", c_mul, is_mul ? STEPS : 0);
        check("norm_left", c_left, n);
        check("norm_right", c_right, (!special && kind == K_MSB) ? 1 : 0);
        check("round_en", c_round, (!special && !zero_res) ? 1 : 0);
        check("add_sub", c_add, (!special && !is_mul) ? 1 : 0);
        check("load_ops", c_load, 1);
        check("swap_ops", swap0, ed[EXP_W]);
        check("invalid_cleared", inv0, 0);
        check("special_sel", spec_d, special);
        check("invalid_at_done", inv_d, rsvd);
        check("busy_gap", busy_bad, 0);
        check("packw_done", packw_bad, 0);

        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_busy", Busy, 0);
        check("idle_done", Done, 0);
        check("idle_invalid", Invalid, rsvd);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 0);
        reset = 1'b1;

        run_op(2'b00, 0, 0, K_MSB, 0, 0);
        run_op(2'b00, 3, 0, K_HID, 0, 0);
        run_op(2'b00, -40, 0, K_HID, 0, 0);
        run_op(2'b01, 5, 0, K_HID, 5, 0);
        run_op(2'b01, 2, 0, K_ZERO, 3, 0);
        run_op(2'b10, 7, 0, K_HID, 0, 0);
        run_op(2'b10, -3, 0, K_HID, 4, 0);
        run_op(2'b00, -256, 0, K_NEVER, 0, 0);
        run_op(2'b00, 255, 1, K_MSB, 0, 0);
        run_op(2'b01, -1, 0, K_MSB, 0, 1);

        // Invalid left sticky by a reserved op must drop under reset.
        run_op(2'b11, 1, 0, K_MSB, 0, 0);
        #2 reset = 1'b0;
        #1 check("reset_clears_invalid", outs, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted mid-alignment clears every output without waiting for a clock.
        @(negedge clk);
        FpOp = 2'b00; ExpDiff = 9'd20; SpecialIn = 1'b0; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_align", AlignShift, 1);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", outs, 0);
        @(negedge clk);
        check("held_reset_outputs", outs, 0);
        reset = 1'b1;
        run_op(2'b00, 4, 0, K_HID, 2, 0);

        for (int i = 0; i < 40; i++) begin
            int e;
            e = int'($urandom_range(0, 511)) - 256;
            if ($urandom_range(0, 1) == 1) e = int'($urandom_range(0, 60)) - 30;
            run_op(2'($urandom_range(0, 3)), e, ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, STEPS)),
                   ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_seq_ctrl.md
# fpu_seq_ctrl

Multi-cycle sequencer for the shared iterative floating-point datapath: single-precision add, subtract and multiply. Launched by the main control FSM while it sits in its FP-execute state. Drives per-cycle step strobes for operand load, alignment, add or shift-add multiply, normalization, rounding and pack. Returns a one-cycle `Done` so the main FSM can advance to FP writeback.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored mantissa width. `ALIGN_MAX = MAN_W+3` (derived, not overridable).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `Start` in 1: launch request, sampled only in IDLE.
- `FpOp` in 2: 00 add, 01 sub, 10 mul, 11 reserved.
- `ExpDiff` in EXP_W+1: signed expA−expB from datapath, valid in LOAD.
- `SpecialIn` in 1: NaN/Inf/zero operand detected, valid in LOAD.
- `ResMsb` in 1: result bit MAN_W+1 (mantissa overflow).
- `ResHidden` in 1: result bit MAN_W.
- `ResZero` in 1: result mantissa all zero.
- `LoadOps` out 1: capture unpacked operands.
- `SwapOps` out 1: swap A/B so the larger exponent is A.
- `AlignShift` out 1: shift smaller mantissa right 1 with sticky.
- `AddSub` out 1: perform mantissa add/sub (sub when FpOp=01).
- `MulStep` out 1: one shift-add multiply iteration.
- `NormLeft` out 1: shift result left 1, decrement exponent.
- `NormRight` out 1: shift result right 1, increment exponent.
- `RoundEn` out 1: round-to-nearest-even step.
- `PackW` out 1: write packed result register.
- `SpecialSel` out 1: pack selects special-case result.
- `Invalid` out 1: sticky; reserved op seen; cleared on next accepted Start.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse, coincident with PackW.

## Operation
- States: IDLE, LOAD, ALIGN, ADD, MUL, NORM, ROUND, PACK.
- **IDLE**: all strobes 0. Start=1 → LOAD; clear Invalid.
- **LOAD** (1 cycle): LoadOps=1.
  - SwapOps=1 iff ExpDiff negative.
  - Counter ← min(|ExpDiff|, ALIGN_MAX).
  - SpecialIn or FpOp=11 → PACK with SpecialSel latched; FpOp=11 also sets Invalid.
  - FpOp=10 → MUL, counter ← MAN_W+1.
  - Otherwise: counter>0 → ALIGN, else ADD.
- **ALIGN**: AlignShift=1 every cycle, counter decrements. Leave for ADD in the cycle counter reaches 1.
- **ADD** (1 cycle): AddSub=1 → NORM.
- **MUL**: MulStep=1 for exactly MAN_W+1 cycles → NORM.
- **NORM**, priority order:
  - ResZero → PACK.
  - ResMsb → NormRight=1 → ROUND.
  - ResHidden → ROUND (no shift).
  - Else NormLeft=1 and stay.
  - Left shifts are bounded by MAN_W+1 (counter reloaded on NORM entry). On exhaustion → ROUND; the datapath handles underflow.
- **ROUND** (1 cycle): RoundEn=1 → PACK. Round carry-out is renormalized inside the datapath.
- **PACK** (1 cycle): PackW=1, Done=1 → IDLE.
- Start while Busy is ignored; there is no queueing.

## Timing
- Reset (asserted low, any state, mid-operation included): state=IDLE, counter=0. Every output 0, Invalid included, immediately and asynchronously.
- All strobes are Moore outputs, decoded from registered state only.
- Cycle 0 is the first cycle in LOAD. Done occurs at cycle:
  - add/sub: 4 + a + n
  - mul: 4 + (MAN_W+1) + n
  - special: 1
- a = min(|ExpDiff|, ALIGN_MAX).
- n = NORM cycles − 1: the count of left shifts, or 0 for a right shift or already-normalized result. ResZero skips ROUND (one cycle less).
- Back-to-back: Start may be high in the IDLE cycle right after PACK; minimum issue interval is 1 + latency.
- ExpDiff = most negative value: |ExpDiff| is computed in EXP_W+2 bits, so there is no overflow; clamps to ALIGN_MAX.

## Configuration
- `FPU_SEQ_MUL_EN` defined: MUL state and MulStep present.
- Not defined: MUL state absent; MulStep tied 0; FpOp=10 handled as reserved (SpecialSel=1, Invalid=1, Done at cycle 1).

## Structure
- Shared package `fpu_pkg`:
  - state enum
  - FpOp encodings (FP_ADD, FP_SUB, FP_MUL, FP_RSVD)
  - EXP_W/MAN_W defaults
  - ALIGN_MAX
- Sub-module `fpu_step_counter`: load value, decrement enable, `last` (count==1) and `zero` flags. Width is the ceiling of log2(MAN_W+4).

## Test plan
- 1.0+1.0: FpOp=00, ExpDiff=0, NORM sees ResMsb=1 → NormRight 1 cycle; Done at cycle 4; AlignShift never asserted.
- ExpDiff=3 add, ResHidden=1 in NORM → AlignShift high for exactly 3 cycles; Done at cycle 7.
- ExpDiff=−40 → SwapOps=1 in LOAD; AlignShift high 26 cycles.
- Sub with ResHidden low for 5 NORM cycles → 5 NormLeft pulses then ROUND; ResZero case goes NORM→PACK, RoundEn never asserted.
- Mul (macro on) → MulStep high exactly 24 cycles; Done at cycle 28 with n=0. Macro off → Invalid=1, Done at cycle 1.
- Reset low during ALIGN → all outputs 0 at once. After reset high, Start → normal fresh operation. Start held high during Busy → no second launch.
